// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t          : sequencing FSM states (RUN / MEM_WAIT / ERR)
//   FWD_REG/MEM/WB   : 2-bit EX operand forwarding selects, also decoded by
//                      the datapath EX operand muxes
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage forwarding select for one source operand (pure combinational).
// Ports:
//   rs_addr      in  5  EX-stage source register index
//   rd_addr_m    in  5  MEM-stage destination
//   reg_write_m  in  1  MEM-stage writes rd
//   rd_addr_w    in  5  WB-stage destination
//   reg_write_w  in  1  WB-stage writes rd
//   sel          out 2  FWD_MEM / FWD_WB / FWD_REG
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr,
    input  logic [4:0] rd_addr_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_addr_w,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    always_comb begin
        sel = FWD_REG;
        if (reg_write_m && (rd_addr_m != 5'd0) && (rd_addr_m == rs_addr)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_addr_w != 5'd0) && (rd_addr_w == rs_addr)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for a 5-stage datapath.
// Drives per-stage stall/flush for load-use hazards, EX redirects and
// data-memory wait states; generates EX operand forwarding selects; keeps a
// saturating stall-cycle counter and a one-cycle memory-timeout error pulse.
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   rs1/rs2_addr_D               ID-stage source indices
//   rs1/rs2_addr_E, rd_addr_E    EX-stage source/destination indices
//   dmem_read_E, pc_src_E        EX is a load / EX redirect taken
//   rd_addr_M, RegWrite_M        MEM-stage destination and write enable
//   dmem_req_M, dmem_ready       MEM access pending / memory completes
//   rd_addr_W, RegWrite_W        WB-stage destination and write enable
//   stall_F/D/E/M, flush_D/E     pipeline register controls
//   forward_A_E, forward_B_E     EX operand forwarding selects
//   mem_err                      one-cycle pulse on memory timeout
//   stall_cycles                 saturating count of cycles with stall_F=1
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_addr_E,
    input  logic             dmem_read_E,
    input  logic             pc_src_E,
    input  logic [4:0]       rd_addr_M,
    input  logic             RegWrite_M,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    input  logic [4:0]       rd_addr_W,
    input  logic             RegWrite_W,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       forward_A_E,
    output logic [1:0]       forward_B_E,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] fwd_a, fwd_b;
    logic       lu;

    hazard_fwd_sel u_fwd_a (
        .rs_addr     (rs1_addr_E),
        .rd_addr_m   (rd_addr_M),
        .reg_write_m (RegWrite_M),
        .rd_addr_w   (rd_addr_W),
        .reg_write_w (RegWrite_W),
        .sel         (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_addr     (rs2_addr_E),
        .rd_addr_m   (rd_addr_M),
        .reg_write_m (RegWrite_M),
        .rd_addr_w   (rd_addr_W),
        .reg_write_w (RegWrite_W),
        .sel         (fwd_b)
    );

    assign lu = dmem_read_E && (rd_addr_E != 5'd0) &&
                ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        stall_F      = 1'b0;
        stall_D      = 1'b0;
        stall_E      = 1'b0;
        stall_M      = 1'b0;
        flush_D      = 1'b0;
        flush_E      = 1'b0;
        forward_A_E  = fwd_a;
        forward_B_E  = fwd_b;

        case (state)
            RUN: begin
                if (dmem_req_M && !dmem_ready) begin
                    {stall_F, stall_D, stall_E, stall_M} = '1;
                    wait_cnt_nxt = 8'd1;
                    state_nxt    = MEM_WAIT;
                end else if (pc_src_E) begin
                    // The load-dependent instruction is flushed by the redirect.
                    flush_D = 1'b1;
                    flush_E = 1'b1;
                end else if (lu) begin
                    // The injected bubble zeroes rd_addr_E, so lu self-clears.
                    stall_F = 1'b1;
                    stall_D = 1'b1;
                    flush_E = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Stalls release in the same cycle the memory reports ready.
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else begin
                    {stall_F, stall_D, stall_E, stall_M} = '1;
                    if (wait_cnt == TIMEOUT) begin
                        state_nxt = ERR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
            end
            ERR: begin
                flush_D      = 1'b1;
                flush_E      = 1'b1;
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase

        // Reset overrides every output asynchronously: flush, never stall.
        if (!reset_n) begin
            {stall_F, stall_D, stall_E, stall_M} = '0;
            flush_D     = 1'b1;
            flush_E     = 1'b1;
            forward_A_E = FWD_REG;
            forward_B_E = FWD_REG;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // Registered so the pulse coincides with the cycle spent in ERR.
            mem_err  <= (state_nxt == ERR);
            if (stall_F && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle RUN vectors
// plus hand-written multi-cycle sequences (memory wait, timeout, counter
// saturation, reset during a memory wait).
module tb_hazard_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_addr_E;
    logic       dmem_read_E, pc_src_E;
    logic [4:0] rd_addr_M, rd_addr_W;
    logic       RegWrite_M, RegWrite_W, dmem_req_M, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
    logic [1:0] forward_A_E, forward_B_E;
    logic       mem_err;
    logic [3:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rs1_addr_D   (rs1_addr_D),
        .rs2_addr_D   (rs2_addr_D),
        .rs1_addr_E   (rs1_addr_E),
        .rs2_addr_E   (rs2_addr_E),
        .rd_addr_E    (rd_addr_E),
        .dmem_read_E  (dmem_read_E),
        .pc_src_E     (pc_src_E),
        .rd_addr_M    (rd_addr_M),
        .RegWrite_M   (RegWrite_M),
        .dmem_req_M   (dmem_req_M),
        .dmem_ready   (dmem_ready),
        .rd_addr_W    (rd_addr_W),
        .RegWrite_W   (RegWrite_W),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .stall_E      (stall_E),
        .stall_M      (stall_M),
        .flush_D      (flush_D),
        .flush_E      (flush_E),
        .forward_A_E  (forward_A_E),
        .forward_B_E  (forward_B_E),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic       ld_e, pc_src;
        logic [4:0] rd_m;
        logic       rw_m;
        logic [4:0] rd_w;
        logic       rw_w;
        logic       ready;
        logic [3:0] e_stall;   // {F,D,E,M}
        logic [1:0] e_flush;   // {D,E}
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [3:0] es, input logic [1:0] ef);
        chk({name, ".stall"}, 32'({stall_F, stall_D, stall_E, stall_M}), 32'(es));
        chk({name, ".flush"}, 32'({flush_D, flush_E}), 32'(ef));
    endtask

    task automatic set_idle();
        rs1_addr_D = '0; rs2_addr_D = '0; rs1_addr_E = '0; rs2_addr_E = '0;
        rd_addr_E = '0; dmem_read_E = 1'b0; pc_src_E = 1'b0;
        rd_addr_M = '0; RegWrite_M = 1'b0; rd_addr_W = '0; RegWrite_W = 1'b0;
        dmem_req_M = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu();
        dmem_read_E = 1'b1; rd_addr_E = 5'd5; rs1_addr_D = 5'd5;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rs1d rs2d rs1e rs2e rde ld pc rdm rwm rdw rww rdy stall    flush  fa     fb
        tbl[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 0, 5'd0, 0, 0, 4'b1100, 2'b01, 2'b00, 2'b00};
        tbl[2]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{5'd3, 5'd9, 5'd0, 5'd0, 5'd9, 1, 0, 5'd0, 0, 5'd0, 0, 0, 4'b1100, 2'b01, 2'b00, 2'b00};
        tbl[4]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[5]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 2'b11, 2'b00, 2'b00};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 2'b11, 2'b00, 2'b00};
        tbl[7]  = '{5'd0, 5'd0, 5'd7, 5'd3, 5'd0, 0, 0, 5'd7, 1, 5'd7, 1, 0, 4'b0000, 2'b00, 2'b10, 2'b00};
        tbl[8]  = '{5'd0, 5'd0, 5'd7, 5'd3, 5'd0, 0, 0, 5'd0, 1, 5'd7, 1, 0, 4'b0000, 2'b00, 2'b01, 2'b00};
        tbl[9]  = '{5'd0, 5'd0, 5'd4, 5'd12, 5'd0, 0, 0, 5'd12, 1, 5'd4, 1, 0, 4'b0000, 2'b00, 2'b01, 2'b10};
        tbl[10] = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 0, 0, 5'd7, 0, 5'd7, 1, 0, 4'b0000, 2'b00, 2'b01, 2'b01};
        tbl[11] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 5'd7, 0, 5'd7, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 1, 0, 4'b0000, 2'b00, 2'b00, 2'b00};
        tbl[13] = '{5'd2, 5'd6, 5'd6, 5'd6, 5'd6, 1, 0, 5'd6, 1, 5'd6, 1, 1, 4'b1100, 2'b01, 2'b10, 2'b10};

        // Reset: outputs forced even with matching forwarding inputs.
        set_idle();
        reset_n = 1'b0;
        RegWrite_M = 1'b1; rd_addr_M = 5'd7; rs1_addr_E = 5'd7; rs2_addr_E = 5'd7;
        set_lu();
        #2;
        chk_ctl("reset", 4'b0000, 2'b11);
        chk("reset.fa", 32'(forward_A_E), 32'(2'b00));
        chk("reset.fb", 32'(forward_B_E), 32'(2'b00));
        chk("reset.cnt", 32'(stall_cycles), 32'd0);
        chk("reset.err", 32'(mem_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_idle();

        // Table of single-cycle RUN vectors.
        exp_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            next_cycle();
            rs1_addr_D = tbl[i].rs1_d; rs2_addr_D = tbl[i].rs2_d;
            rs1_addr_E = tbl[i].rs1_e; rs2_addr_E = tbl[i].rs2_e;
            rd_addr_E  = tbl[i].rd_e;  dmem_read_E = tbl[i].ld_e;
            pc_src_E   = tbl[i].pc_src;
            rd_addr_M  = tbl[i].rd_m;  RegWrite_M = tbl[i].rw_m;
            rd_addr_W  = tbl[i].rd_w;  RegWrite_W = tbl[i].rw_w;
            dmem_req_M = 1'b0;         dmem_ready = tbl[i].ready;
            #3;
            chk($sformatf("vec%0d", i) , 32'({stall_F, stall_D, stall_E, stall_M}), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d.flush", i), 32'({flush_D, flush_E}), 32'(tbl[i].e_flush));
            chk($sformatf("vec%0d.fa", i), 32'(forward_A_E), 32'(tbl[i].e_fa));
            chk($sformatf("vec%0d.fb", i), 32'(forward_B_E), 32'(tbl[i].e_fb));
            if (tbl[i].e_stall[3]) exp_cnt++;
        end
        next_cycle();
        set_idle();
        #3;
        chk("cnt.after_table", 32'(stall_cycles), 32'(exp_cnt));

        // Memory wait: ready low 3 cycles then high; mem_wait beats redirect and lu.
        next_cycle();
        dmem_req_M = 1'b1; dmem_ready = 1'b0; pc_src_E = 1'b1; set_lu();
        #3;
        chk_ctl("wait.enter", 4'b1111, 2'b00);
        chk("wait.enter.err", 32'(mem_err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            #3;
            chk_ctl($sformatf("wait.hold%0d", i), 4'b1111, 2'b00);
            chk($sformatf("wait.hold%0d.err", i), 32'(mem_err), 32'd0);
        end
        next_cycle();
        dmem_ready = 1'b1;
        #3;
        chk_ctl("wait.ready", 4'b0000, 2'b00);
        next_cycle();
        set_idle();
        #3;
        chk_ctl("wait.run", 4'b0000, 2'b00);
        chk("wait.run.err", 32'(mem_err), 32'd0);
        chk("cnt.after_wait", 32'(stall_cycles), 32'd6);

        // Timeout: ready never comes, MEM_TIMEOUT=4.
        next_cycle();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        #3;
        chk_ctl("to.enter", 4'b1111, 2'b00);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #3;
            chk_ctl($sformatf("to.hold%0d", i), 4'b1111, 2'b00);
            chk($sformatf("to.hold%0d.err", i), 32'(mem_err), 32'd0);
        end
        next_cycle();
        dmem_req_M = 1'b0;
        #3;
        chk("to.err_pulse", 32'(mem_err), 32'd1);
        chk_ctl("to.err", 4'b0000, 2'b11);
        next_cycle();
        #3;
        chk("to.err_cleared", 32'(mem_err), 32'd0);
        chk_ctl("to.run", 4'b0000, 2'b00);
        chk("cnt.after_timeout", 32'(stall_cycles), 32'd11);

        // Counter saturation: 6 more stall cycles from 11 must stop at 15.
        next_cycle();
        set_lu();
        repeat (6) next_cycle();
        set_idle();
        #3;
        chk("cnt.saturated", 32'(stall_cycles), 32'd15);

        // Reset asserted during MEM_WAIT.
        next_cycle();
        dmem_req_M = 1'b1; dmem_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        chk_ctl("rst_mid.before", 4'b1111, 2'b00);
        reset_n = 1'b0;
        RegWrite_M = 1'b1; rd_addr_M = 5'd7; rs1_addr_E = 5'd7; rs2_addr_E = 5'd7;
        #1;
        chk_ctl("rst_mid", 4'b0000, 2'b11);
        chk("rst_mid.fa", 32'(forward_A_E), 32'(2'b00));
        chk("rst_mid.cnt", 32'(stall_cycles), 32'd0);
        chk("rst_mid.err", 32'(mem_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dmem_req_M = 1'b0;
        #1;
        chk("rst_mid.fa_after", 32'(forward_A_E), 32'(2'b10));
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            #3;
            chk_ctl($sformatf("rst_mid.run%0d", i), 4'b0000, 2'b00);
            chk($sformatf("rst_mid.run%0d.err", i), 32'(mem_err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
